// File: rtl/dma_ram_rd_arbiter.sv
// Segmented DMA RAM read-port arbiter: per-segment requester selection plus tag FIFO for in-order response return.
// Optional feature macro: DMA_RAM_RD_ARB_RR_EN (round-robin arbitration; fixed priority when undefined).
module dma_ram_rd_arbiter #(
    parameter int unsigned PORTS          = 2,
    parameter int unsigned SEG_COUNT      = 2,
    parameter int unsigned SEG_DATA_WIDTH = 128,
    parameter int unsigned SEG_ADDR_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH     = 16
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [PORTS*SEG_COUNT*SEG_ADDR_WIDTH-1:0]  s_rd_cmd_addr,
    input  logic [PORTS*SEG_COUNT-1:0]                 s_rd_cmd_valid,
    output logic [PORTS*SEG_COUNT-1:0]                 s_rd_cmd_ready,
    output logic [PORTS*SEG_COUNT*SEG_DATA_WIDTH-1:0]  s_rd_resp_data,
    output logic [PORTS*SEG_COUNT-1:0]                 s_rd_resp_valid,
    input  logic [PORTS*SEG_COUNT-1:0]                 s_rd_resp_ready,
    output logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0]        m_rd_cmd_addr,
    output logic [SEG_COUNT-1:0]                       m_rd_cmd_valid,
    input  logic [SEG_COUNT-1:0]                       m_rd_cmd_ready,
    input  logic [SEG_COUNT*SEG_DATA_WIDTH-1:0]        m_rd_resp_data,
    input  logic [SEG_COUNT-1:0]                       m_rd_resp_valid,
    output logic [SEG_COUNT-1:0]                       m_rd_resp_ready
);

    localparam int unsigned TAG_W = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    for (genvar n = 0; n < int'(SEG_COUNT); n++) begin : g_seg
        logic [TAG_W-1:0]                     r_rr_ptr;
        logic [TAG_W-1:0]                     r_tag_mem [FIFO_DEPTH];
        logic [PTR_W-1:0]                     r_wr_ptr;
        logic [PTR_W-1:0]                     r_rd_ptr;
        logic [CNT_W-1:0]                     r_count;
        logic [PORTS-1:0]                     w_valid;
        logic [PORTS-1:0]                     w_rready;
        logic [PORTS-1:0][SEG_ADDR_WIDTH-1:0] w_addr;
        logic [TAG_W-1:0]                     w_sel;
        logic [TAG_W-1:0]                     w_head;
        logic [TAG_W-1:0]                     w_rr_next;
        logic                                 w_any_valid;
        logic                                 w_full;
        logic                                 w_empty;
        logic                                 w_push;
        logic                                 w_pop;
        int                                   w_idx;

        // Gather this segment's per-port slices into port-indexed vectors
        for (genvar p = 0; p < int'(PORTS); p++) begin : g_port
            assign w_valid[p]  = s_rd_cmd_valid[p*SEG_COUNT+n];
            assign w_rready[p] = s_rd_resp_ready[p*SEG_COUNT+n];
            assign w_addr[p]   = s_rd_cmd_addr[(p*SEG_COUNT+n)*SEG_ADDR_WIDTH +: SEG_ADDR_WIDTH];
            assign s_rd_cmd_ready[p*SEG_COUNT+n] = rst_n && w_any_valid && (w_sel == TAG_W'(p))
                                                   && m_rd_cmd_ready[n] && !w_full;
            assign s_rd_resp_valid[p*SEG_COUNT+n] = rst_n && m_rd_resp_valid[n] && !w_empty
                                                    && (w_head == TAG_W'(p));
            assign s_rd_resp_data[(p*SEG_COUNT+n)*SEG_DATA_WIDTH +: SEG_DATA_WIDTH] =
                m_rd_resp_data[n*SEG_DATA_WIDTH +: SEG_DATA_WIDTH];
        end

        // Requester selection: first valid port scanning upward from the start point
        always_comb begin
            w_any_valid = 1'b0;
            w_sel       = '0;
            w_idx       = 0;
            for (int i = 0; i < int'(PORTS); i++) begin
`ifdef DMA_RAM_RD_ARB_RR_EN
                w_idx = int'(r_rr_ptr) + i;
                if (w_idx >= int'(PORTS)) begin
                    w_idx = w_idx - int'(PORTS);
                end
`else
                w_idx = i;
`endif
                if (!w_any_valid && w_valid[TAG_W'(w_idx)]) begin
                    w_any_valid = 1'b1;
                    w_sel       = TAG_W'(w_idx);
                end
            end
        end

        assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
        assign w_empty   = (r_count == '0);
        assign w_head    = r_tag_mem[r_rd_ptr];
        assign w_push    = w_any_valid && !w_full && m_rd_cmd_ready[n];
        assign w_pop     = m_rd_resp_valid[n] && !w_empty && w_rready[w_head];
        assign w_rr_next = (int'(w_sel) == int'(PORTS) - 1) ? '0 : w_sel + TAG_W'(1);

        assign m_rd_cmd_valid[n]                                  = rst_n && w_any_valid && !w_full;
        assign m_rd_cmd_addr[n*SEG_ADDR_WIDTH +: SEG_ADDR_WIDTH]  = w_addr[w_sel];
        assign m_rd_resp_ready[n]                                 = rst_n && !w_empty && w_rready[w_head];

        // Tag storage needs no reset: entries are only read once written
        always_ff @(posedge clk) begin
            if (w_push) begin
                r_tag_mem[r_wr_ptr] <= w_sel;
            end
        end

        // Pointers, occupancy and grant pointer; full uses the registered count
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rr_ptr <= '0;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                    if (w_rr_next != r_rr_ptr) begin
                        r_rr_ptr <= w_rr_next;
                    end
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dma_ram_rd_arbiter.sv
// Directed bench for dma_ram_rd_arbiter (PORTS=2, SEG_COUNT=2, FIFO_DEPTH=16).
module tb_dma_ram_rd_arbiter;

    localparam int P  = 2;
    localparam int S  = 2;
    localparam int DW = 128;
    localparam int AW = 8;
    localparam int D  = 16;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [P*S*AW-1:0]   s_rd_cmd_addr;
    logic [P*S-1:0]      s_rd_cmd_valid;
    logic [P*S-1:0]      s_rd_cmd_ready;
    logic [P*S*DW-1:0]   s_rd_resp_data;
    logic [P*S-1:0]      s_rd_resp_valid;
    logic [P*S-1:0]      s_rd_resp_ready;
    logic [S*AW-1:0]     m_rd_cmd_addr;
    logic [S-1:0]        m_rd_cmd_valid;
    logic [S-1:0]        m_rd_cmd_ready;
    logic [S*DW-1:0]     m_rd_resp_data;
    logic [S-1:0]        m_rd_resp_valid;
    logic [S-1:0]        m_rd_resp_ready;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    dma_ram_rd_arbiter #(
        .PORTS(P), .SEG_COUNT(S), .SEG_DATA_WIDTH(DW), .SEG_ADDR_WIDTH(AW), .FIFO_DEPTH(D)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_rd_cmd_addr(s_rd_cmd_addr), .s_rd_cmd_valid(s_rd_cmd_valid), .s_rd_cmd_ready(s_rd_cmd_ready),
        .s_rd_resp_data(s_rd_resp_data), .s_rd_resp_valid(s_rd_resp_valid), .s_rd_resp_ready(s_rd_resp_ready),
        .m_rd_cmd_addr(m_rd_cmd_addr), .m_rd_cmd_valid(m_rd_cmd_valid), .m_rd_cmd_ready(m_rd_cmd_ready),
        .m_rd_resp_data(m_rd_resp_data), .m_rd_resp_valid(m_rd_resp_valid), .m_rd_resp_ready(m_rd_resp_ready)
    );

    // Inputs change 1 time unit after the rising edge; checks happen 1 unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s_rd_cmd_addr   = '0;
        s_rd_cmd_valid  = '0;
        s_rd_resp_ready = '1;
        m_rd_cmd_ready  = '1;
        m_rd_resp_data  = '0;
        m_rd_resp_valid = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_rd_cmd_valid  = '1;
        m_rd_cmd_ready  = '1;
        m_rd_resp_valid = '1;
        s_rd_resp_ready = '1;
        #1;
        total_cnt++;
        if ({m_rd_cmd_valid, s_rd_cmd_ready, s_rd_resp_valid, m_rd_resp_ready} !== '0) begin
            $display("FAIL reset_outputs: got %b required 0",
                     {m_rd_cmd_valid, s_rd_cmd_ready, s_rd_resp_valid, m_rd_resp_ready});
        end else pass_cnt++;
        tick();
        tick();
        idle_inputs();
        rst_n = 1'b1;
        tick();
        // Stray RAM response into an empty FIFO must not be routed or acknowledged
        m_rd_resp_valid = 2'b11;
        #1;
        total_cnt++;
        if ({s_rd_resp_valid, m_rd_resp_ready} !== 6'b0) begin
            $display("FAIL empty_resp: got %b required 0", {s_rd_resp_valid, m_rd_resp_ready});
        end else pass_cnt++;
        tick();
        idle_inputs();
    endtask

    task automatic test_single_read();
        s_rd_cmd_addr[2*AW +: AW] = 8'h12;
        s_rd_cmd_valid = 4'b0100;
        #1;
        total_cnt++;
        if (m_rd_cmd_addr[AW-1:0] !== 8'h12 || m_rd_cmd_valid !== 2'b01) begin
            $display("FAIL single_cmd: addr %h valid %b required 12 01", m_rd_cmd_addr[AW-1:0], m_rd_cmd_valid);
        end else pass_cnt++;
        total_cnt++;
        if (s_rd_cmd_ready !== 4'b0100) begin
            $display("FAIL single_ready: got %b required 0100", s_rd_cmd_ready);
        end else pass_cnt++;
        tick();
        s_rd_cmd_valid = '0;
        tick();
        m_rd_resp_valid = 2'b01;
        m_rd_resp_data[DW-1:0] = 128'hA5;
        #1;
        total_cnt++;
        if (s_rd_resp_valid !== 4'b0100 || s_rd_resp_data[2*DW +: DW] !== 128'hA5) begin
            $display("FAIL single_resp: valid %b data %h required 0100 a5", s_rd_resp_valid, s_rd_resp_data[2*DW +: DW]);
        end else pass_cnt++;
        tick();
        #1;
        total_cnt++;
        if (s_rd_resp_valid !== 4'b0000 || m_rd_resp_ready !== 2'b00) begin
            $display("FAIL single_drained: valid %b ready %b required 0000 00", s_rd_resp_valid, m_rd_resp_ready);
        end else pass_cnt++;
        idle_inputs();
    endtask

    task automatic test_contention();
        logic [P*S-1:0] exp;
        int errs;
        s_rd_cmd_valid = 4'b0101;
        errs = 0;
        for (int i = 0; i < 6; i++) begin
`ifdef DMA_RAM_RD_ARB_RR_EN
            exp = (i % 2 == 0) ? 4'b0001 : 4'b0100;
`else
            exp = 4'b0001;
`endif
            #1;
            total_cnt++;
            if (s_rd_cmd_ready !== exp) begin
                $display("FAIL contention_grant%0d: got %b required %b", i, s_rd_cmd_ready, exp);
            end else pass_cnt++;
            tick();
        end
        s_rd_cmd_valid = '0;
        m_rd_resp_valid = 2'b01;
        for (int i = 0; i < 6; i++) begin
`ifdef DMA_RAM_RD_ARB_RR_EN
            exp = (i % 2 == 0) ? 4'b0001 : 4'b0100;
`else
            exp = 4'b0001;
`endif
            #1;
            if (s_rd_resp_valid !== exp) begin
                $display("FAIL contention_resp%0d: got %b required %b", i, s_rd_resp_valid, exp);
                errs++;
            end
            tick();
        end
        total_cnt++;
        if (errs == 0) pass_cnt++;
        idle_inputs();
    endtask

    task automatic test_ordering();
        logic [7:0] addrs [3];
        logic [P*S-1:0] vlds [3];
        addrs = '{8'h01, 8'h02, 8'h03};
        vlds  = '{4'b0001, 4'b0001, 4'b0100};
        for (int i = 0; i < 3; i++) begin
            s_rd_cmd_addr = '0;
            s_rd_cmd_addr[0 +: AW]    = (vlds[i] == 4'b0001) ? addrs[i] : 8'h00;
            s_rd_cmd_addr[2*AW +: AW] = (vlds[i] == 4'b0100) ? addrs[i] : 8'h00;
            s_rd_cmd_valid = vlds[i];
            #1;
            total_cnt++;
            if (m_rd_cmd_addr[AW-1:0] !== addrs[i] || s_rd_cmd_ready !== vlds[i]) begin
                $display("FAIL order_cmd%0d: addr %h ready %b required %h %b", i, m_rd_cmd_addr[AW-1:0], s_rd_cmd_ready, addrs[i], vlds[i]);
            end else pass_cnt++;
            tick();
        end
        s_rd_cmd_valid = '0;
        m_rd_resp_valid = 2'b01;
        for (int i = 0; i < 3; i++) begin
            m_rd_resp_data[DW-1:0] = 128'hD0 + 128'(i + 1);
            #1;
            total_cnt++;
            if (s_rd_resp_valid !== vlds[i] ||
                s_rd_resp_data[(vlds[i] == 4'b0001 ? 0 : 2)*DW +: DW] !== 128'hD0 + 128'(i + 1)) begin
                $display("FAIL order_resp%0d: valid %b required %b", i, s_rd_resp_valid, vlds[i]);
            end else pass_cnt++;
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_full();
        int acc;
        s_rd_cmd_valid = 4'b0001;
        acc = 0;
        for (int i = 0; i < D; i++) begin
            #1;
            if (s_rd_cmd_ready[0] === 1'b1) acc++;
            tick();
        end
        total_cnt++;
        if (acc != D) begin
            $display("FAIL full_fill: accepted %0d required %0d", acc, D);
        end else pass_cnt++;
        // Full with a simultaneous pop: readies still low
        s_rd_cmd_valid  = 4'b0101;
        m_rd_resp_valid = 2'b01;
        #1;
        total_cnt++;
        if (s_rd_cmd_ready !== 4'b0000 || m_rd_cmd_valid[0] !== 1'b0 || m_rd_resp_ready[0] !== 1'b1) begin
            $display("FAIL full_block: ready %b cmd_valid %b resp_ready %b required 0000 0 1", s_rd_cmd_ready, m_rd_cmd_valid[0], m_rd_resp_ready[0]);
        end else pass_cnt++;
        tick();
        m_rd_resp_valid = 2'b00;
        s_rd_cmd_valid  = 4'b0001;
        #1;
        total_cnt++;
        if (s_rd_cmd_ready !== 4'b0001) begin
            $display("FAIL full_one_slot: got %b required 0001", s_rd_cmd_ready);
        end else pass_cnt++;
        tick();
        #1;
        total_cnt++;
        if (s_rd_cmd_ready !== 4'b0000) begin
            $display("FAIL full_again: got %b required 0000", s_rd_cmd_ready);
        end else pass_cnt++;
        s_rd_cmd_valid  = '0;
        m_rd_resp_valid = 2'b01;
        acc = 0;
        for (int i = 0; i < D + 1; i++) begin
            #1;
            if (s_rd_resp_valid === 4'b0001) acc++;
            tick();
        end
        total_cnt++;
        if (acc != D) begin
            $display("FAIL full_drain: delivered %0d required %0d", acc, D);
        end else pass_cnt++;
        idle_inputs();
    endtask

    task automatic test_backpressure();
        s_rd_cmd_valid = 4'b0110;
        tick();
        s_rd_cmd_valid = 4'b0010;
        tick();
        tick();
        s_rd_cmd_valid = '0;
        m_rd_resp_valid = 2'b11;
        m_rd_resp_data  = {128'h2222, 128'h1111};
        s_rd_resp_ready = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            #1;
            total_cnt++;
            if (m_rd_resp_ready !== 2'b10 || s_rd_resp_valid !== 4'b0110) begin
                $display("FAIL bp_stall%0d: resp_ready %b valid %b required 10 0110", i, m_rd_resp_ready, s_rd_resp_valid);
            end else pass_cnt++;
            tick();
        end
        s_rd_resp_ready = 4'b1111;
        m_rd_resp_valid = 2'b01;
        #1;
        total_cnt++;
        if (m_rd_resp_ready !== 2'b01 || s_rd_resp_valid !== 4'b0100 || s_rd_resp_data[2*DW +: DW] !== 128'h1111) begin
            $display("FAIL bp_release: resp_ready %b valid %b data %h required 01 0100 1111", m_rd_resp_ready, s_rd_resp_valid, s_rd_resp_data[2*DW +: DW]);
        end else pass_cnt++;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        s_rd_cmd_valid = 4'b0100;
        for (int i = 0; i < 5; i++) tick();
        s_rd_cmd_valid  = 4'b0101;
        m_rd_resp_valid = 2'b01;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({m_rd_cmd_valid, s_rd_cmd_ready, s_rd_resp_valid, m_rd_resp_ready} !== '0) begin
            $display("FAIL midreset_outputs: got %b required 0",
                     {m_rd_cmd_valid, s_rd_cmd_ready, s_rd_resp_valid, m_rd_resp_ready});
        end else pass_cnt++;
        tick();
        s_rd_cmd_valid = '0;
        rst_n = 1'b1;
        tick();
        #1;
        total_cnt++;
        if (s_rd_resp_valid !== 4'b0000 || m_rd_resp_ready !== 2'b00) begin
            $display("FAIL midreset_empty: valid %b ready %b required 0000 00", s_rd_resp_valid, m_rd_resp_ready);
        end else pass_cnt++;
        m_rd_resp_valid = 2'b00;
        s_rd_cmd_valid  = 4'b0101;
        #1;
        total_cnt++;
        if (s_rd_cmd_ready !== 4'b0001) begin
            $display("FAIL midreset_grant: got %b required 0001", s_rd_cmd_ready);
        end else pass_cnt++;
        tick();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b1;
        #2;
        test_reset();
        test_single_read();
        test_contention();
        test_ordering();
        test_full();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/dma_ram_rd_arbiter.md
# dma_ram_rd_arbiter

Shares the read port of a segmented DMA RAM between PORTS requesters, for example a PCIe DMA write engine and a descriptor fetch unit. Each segment is arbitrated independently and has its own command/response handshake. The block records which port issued each accepted read. It returns responses to the issuing port in issue order. It sits between the requesters and the RAM read port (rd_cmd_* / rd_resp_*), adds zero cycles of latency, and is fully combinational on the datapath.

## Interface
- PORTS, 2: number of requesters; must be 2 to 8.
- SEG_COUNT, 2: number of RAM segments.
- SEG_DATA_WIDTH, 128: width of the data in one segment.
- SEG_ADDR_WIDTH, 8: width of the address in one segment.
- FIFO_DEPTH, 16: maximum outstanding reads per segment; must be a power of two and at least 2.
- clk  in  1  block clock; all logic runs in this one clock domain.
- rst_n  in  1  asynchronous active-low reset.
- s_rd_cmd_addr  in  PORTS*SEG_COUNT*SEG_ADDR_WIDTH  requester command address; the slice for port p, segment n is at offset (p*SEG_COUNT+n).
- s_rd_cmd_valid  in  PORTS*SEG_COUNT  requester command valid.
- s_rd_cmd_ready  out  PORTS*SEG_COUNT  requester command ready.
- s_rd_resp_data  out  PORTS*SEG_COUNT*SEG_DATA_WIDTH  response data; the RAM data is copied to every port.
- s_rd_resp_valid  out  PORTS*SEG_COUNT  response valid.
- s_rd_resp_ready  in  PORTS*SEG_COUNT  response ready.
- m_rd_cmd_addr  out  SEG_COUNT*SEG_ADDR_WIDTH  address to the RAM.
- m_rd_cmd_valid  out  SEG_COUNT  command valid to the RAM.
- m_rd_cmd_ready  in  SEG_COUNT  command ready from the RAM.
- m_rd_resp_data  in  SEG_COUNT*SEG_DATA_WIDTH  response data from the RAM.
- m_rd_resp_valid  in  SEG_COUNT  response valid from the RAM.
- m_rd_resp_ready  out  SEG_COUNT  response ready to the RAM.

## Operation
Each segment n has its own independent instance of the following state:
- a grant pointer, `rr_ptr`;
- a tag FIFO of FIFO_DEPTH entries, each $clog2(PORTS) bits wide;
- a write pointer, a read pointer and an occupancy count. The count is $clog2(FIFO_DEPTH)+1 bits wide.

Command path, all combinational:
- `sel` is the valid requester chosen by the arbitration policy (see Configuration).
- m_rd_cmd_valid[n] = (any s_rd_cmd_valid for segment n) && !full.
- m_rd_cmd_addr for segment n = the address of `sel`.
- s_rd_cmd_ready for (`sel`, n) = m_rd_cmd_ready[n] && !full. For every other port it is 0.

A command is accepted when m_rd_cmd_valid[n] && m_rd_cmd_ready[n]. On acceptance:
- `sel` is pushed into the tag FIFO;
- `rr_ptr` becomes (sel+1) mod PORTS.

Response path, all combinational:
- `head` is the tag at the read pointer of the FIFO.
- s_rd_resp_valid for (`head`, n) = m_rd_resp_valid[n] && !empty. For every other port it is 0.
- m_rd_resp_ready[n] = s_rd_resp_ready for (`head`, n) && !empty.

A response completes when m_rd_resp_valid[n] && m_rd_resp_ready[n]. On completion the FIFO pops one entry.

Boundary conditions:
- FIFO full: all command readies for the segment are 0. This holds even if a pop happens in the same cycle; full is evaluated from the registered count.
- FIFO empty: m_rd_resp_ready[n] = 0 and no s_rd_resp_valid is asserted. A RAM response that arrives while the FIFO is empty is a protocol violation; it stalls the segment and is never routed to any port.
- Push and pop in the same cycle: the count is unchanged and both pointers advance.
- Pointers wrap modulo FIFO_DEPTH.
- A requester that drops valid before being granted is legal and is simply skipped by arbitration.

Reset, asserted at any time including mid-transfer:
- every FIFO is emptied;
- `rr_ptr` = 0;
- all valid and ready outputs are 0 while rst_n = 0;
- in-flight RAM responses are discarded. The RAM must be reset at the same time.

## Timing
- Command path and response path each add 0 cycles of latency.
- Peak throughput is one command and one response per segment per cycle.
- The FIFO count, pointers and `rr_ptr` update on the rising edge of clk.
- The occupancy seen by the command path at cycle t includes every push and pop up to cycle t-1.
- Segments never interact; a stall on segment 0 does not affect segment 1.

## Configuration
- Macro: DMA_RAM_RD_ARB_RR_EN.
- When defined, arbitration is round robin. `sel` is the first valid port found searching upward from `rr_ptr`, wrapping past PORTS-1 to 0.
- When not defined, arbitration is fixed priority: `sel` is the lowest-numbered valid port. `rr_ptr` is still maintained but is not used.

## Test plan
- Single read: port 1 requests segment 0 at address 0x12; the RAM returns 0xA5 two cycles later. Required: m_rd_cmd_addr = 0x12 in the same cycle as the request; s_rd_resp_valid for (1,0) asserts with data 0xA5; port 0 never sees a valid.
- Contention (macro defined): ports 0 and 1 hold valid continuously for 6 cycles with RAM ready = 1. Required: grants go 0,1,0,1,0,1. With the macro undefined, all 6 grants go to port 0.
- Ordering: port 0 issues reads at addresses 0x01 and 0x02, then port 1 issues 0x03. The RAM returns D1, D2, D3. Required: D1 and D2 are delivered to port 0 in that order, then D3 to port 1.
- Full FIFO (FIFO_DEPTH = 16): 16 commands are accepted with no responses. Required: on the 17th cycle every s_rd_cmd_ready for the segment = 0. One response pop then allows exactly one new acceptance.
- Backpressure: the head port deasserts s_rd_resp_ready for 3 cycles. Required: m_rd_resp_ready = 0 for those 3 cycles; the data is held and delivered once ready returns; segment 1 continues to flow throughout.
- Reset mid-operation: rst_n is pulled low with 5 reads outstanding. Required: all valids = 0 immediately; after release the FIFO is empty and the first new grant follows the priority order starting from port 0.
